// File: rtl/stack_sequencer.sv
// Stack sequencer: turns push/pop/add/sub/clear/refresh commands into cycles on a
// single-port synchronous stack memory, caching top-of-stack, depth and error flags.
module stack_sequencer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] top_value,
    output logic              top_valid,
    output logic [ADDR_W:0]   depth,
    output logic              carry,
    output logic              err_overflow,
    output logic              err_underflow
);

    typedef enum logic [2:0] {
        IDLE, PUSH_WR, RD_REQ, RD_WAIT, ALU_WR, TOP_REQ, TOP_WAIT
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP, OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_CLEAR, OP_REFRESH, OP_NOP7
    } op_e;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] TWO      = {{(ADDR_W-1){1'b0}}, 2'b10};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     depth_d;
    logic [DATA_W-1:0]   top_d;
    logic                carry_d, ovf_d, unf_d;
    logic                cs_d, we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                is_sub_q, is_sub_d;
    logic                alu_carry_q, alu_carry_d;

    logic [ADDR_W-1:0]   addr_m1, addr_m2;
    logic [DATA_W:0]     sum, diff;

    // Addresses wrap in ADDR_W bits, so a full stack (depth = 2**ADDR_W) still maps correctly.
    assign addr_m1 = depth[ADDR_W-1:0] - ADDR_W'(1);
    assign addr_m2 = depth[ADDR_W-1:0] - ADDR_W'(2);

    // B is the word under the top (fresh from memory), A is the cached top.
    assign sum  = {1'b0, mem_rdata} + {1'b0, top_value};
    assign diff = {1'b0, mem_rdata} - {1'b0, top_value};

    assign cmd_ready = (state_q == IDLE);
    assign top_valid = (depth != '0);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        depth_d     = depth;
        top_d       = top_value;
        carry_d     = carry;
        ovf_d       = err_overflow;
        unf_d       = err_underflow;
        cs_d        = 1'b1;
        we_d        = 1'b0;
        addr_d      = mem_addr;
        wdata_d     = mem_wdata;
        is_sub_d    = is_sub_q;
        alu_carry_d = alu_carry_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (depth == CAPACITY) begin
                                ovf_d = 1'b1;
                            end else begin
                                state_d = PUSH_WR;
                                cs_d    = 1'b0;
                                we_d    = 1'b1;
                                addr_d  = depth[ADDR_W-1:0];
                                wdata_d = cmd_data;
                            end
                        end
                        OP_POP: begin
                            if (depth == '0) begin
                                unf_d = 1'b1;
                            end else if (depth == ONE) begin
                                depth_d = '0;
                                top_d   = '0;
                            end else begin
                                depth_d = depth - ONE;
                                state_d = TOP_REQ;
                                cs_d    = 1'b0;
                                addr_d  = addr_m2;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            if (depth < TWO) begin
                                unf_d = 1'b1;
                            end else begin
                                state_d  = RD_REQ;
                                cs_d     = 1'b0;
                                addr_d   = addr_m2;
                                is_sub_d = (cmd_op == OP_SUB);
                            end
                        end
                        OP_CLEAR: begin
                            depth_d = '0;
                            top_d   = '0;
                            carry_d = 1'b0;
                            ovf_d   = 1'b0;
                            unf_d   = 1'b0;
                        end
                        OP_REFRESH: begin
                            if (depth != '0) begin
                                state_d = TOP_REQ;
                                cs_d    = 1'b0;
                                addr_d  = addr_m1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            PUSH_WR: begin
                depth_d = depth + ONE;
                top_d   = mem_wdata;
                state_d = IDLE;
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Result goes straight into the write-data register; address is still depth-2.
                state_d = ALU_WR;
                cs_d    = 1'b0;
                we_d    = 1'b1;
                if (is_sub_q) begin
                    wdata_d     = diff[DATA_W-1:0];
                    alu_carry_d = diff[DATA_W];
                end else begin
                    wdata_d     = sum[DATA_W-1:0];
                    alu_carry_d = sum[DATA_W];
                end
            end
            ALU_WR: begin
                depth_d = depth - ONE;
                top_d   = mem_wdata;
                carry_d = alu_carry_q;
                state_d = IDLE;
            end
            TOP_REQ: begin
                state_d = TOP_WAIT;
            end
            TOP_WAIT: begin
                top_d   = mem_rdata;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            depth         <= '0;
            top_value     <= '0;
            carry         <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            mem_cs        <= 1'b1;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            is_sub_q      <= 1'b0;
            alu_carry_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            state_q       <= state_d;
            depth         <= depth_d;
            top_value     <= top_d;
            carry         <= carry_d;
            err_overflow  <= ovf_d;
            err_underflow <= unf_d;
            mem_cs        <= cs_d;
            mem_we        <= we_d;
            mem_addr      <= addr_d;
            mem_wdata     <= wdata_d;
            is_sub_q      <= is_sub_d;
            alu_carry_q   <= alu_carry_d;
        end
    end

endmodule
